// File: rtl/core_msg_rx_if.sv
// Task message bus from the scheduler to one core.
// Carries a word-valid strobe and the 16-bit message word.
interface core_msg_rx_if #(
  parameter int BUS_WIDTH = 16
);
  logic                 msg_valid;
  logic [BUS_WIDTH-1:0] msg_data;

  modport master (
    output msg_valid,
    output msg_data
  );

  modport slave (
    input msg_valid,
    input msg_data
  );
endinterface

// File: rtl/core_msg_rx.sv
// Core-side task message receiver: deframes the scheduler word stream,
// writes instruction memory, loads r0 and tracks core busy state.
module core_msg_rx #(
  parameter int CORE_ID      = 0,
  parameter int CORE_NUM     = 16,
  parameter int BUS_WIDTH    = 16,
  parameter int FRAME_SIZE   = 16,
  parameter int R0_DEPTH     = 8,
  parameter int R0_DATA_SIZE = 128,
  parameter int IMEM_AW      = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  core_msg_rx_if.slave            msg,
  input  logic                    exec_done,
  output logic                    core_ready,
  output logic                    imem_we,
  output logic [IMEM_AW-1:0]      imem_addr,
  output logic [BUS_WIDTH-1:0]    imem_wdata,
  output logic [R0_DATA_SIZE-1:0] r0_value,
  output logic                    r0_load,
  output logic                    task_start,
  output logic [1:0]              task_fence,
  output logic                    proto_err
);

  localparam logic [2:0] S_HDR   = 3'd0;
  localparam logic [2:0] S_MASK  = 3'd1;
  localparam logic [2:0] S_R0M   = 3'd2;
  localparam logic [2:0] S_R0D   = 3'd3;
  localparam logic [2:0] S_PAD   = 3'd4;
  localparam logic [2:0] S_INSTR = 3'd5;

  localparam logic [3:0] R0_LAST = 4'(2 + R0_DEPTH);
  localparam logic [3:0] WC_LAST = 4'(FRAME_SIZE - 1);

  logic [2:0]              state;
  logic [3:0]              wc;
  logic [5:0]              if_num;
  logic [5:0]              frame_idx;
  logic                    sel_q;
  logic                    r0_sel_q;
  logic                    busy;
  logic [R0_DATA_SIZE-1:0] staging;
  logic [R0_DATA_SIZE-1:0] staging_nx;
  logic [9:0]              addr_full;
  logic                    hit;
  logic                    frame_end;
  logic                    task_end;
  logic                    start_evt;

  assign core_ready = !busy;
  assign hit        = msg.msg_data[CORE_ID];
  assign frame_end  = msg.msg_valid && (wc == WC_LAST);
  assign addr_full  = {frame_idx, wc};
  assign staging_nx = {msg.msg_data,
                       staging[R0_DATA_SIZE-1:BUS_WIDTH]};

  always_comb begin
    task_end = 1'b0;
    if (frame_end) begin
      if (state == S_PAD)
        task_end = (if_num == 6'd0);
      else if (state == S_INSTR)
        task_end = (frame_idx == 6'(if_num - 6'd1));
    end
  end

  // Selection is frozen at the mask word so a mid-task
  // exec_done cannot promote a rejected task.
  assign start_evt = task_end & sel_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_HDR;
      wc         <= 4'd0;
      if_num     <= 6'd0;
      frame_idx  <= 6'd0;
      sel_q      <= 1'b0;
      r0_sel_q   <= 1'b0;
      busy       <= 1'b0;
      staging    <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      r0_value   <= '0;
      r0_load    <= 1'b0;
      task_start <= 1'b0;
      task_fence <= 2'd0;
      proto_err  <= 1'b0;
    end else begin
      imem_we    <= 1'b0;
      r0_load    <= 1'b0;
      task_start <= start_evt;
      busy       <= start_evt | (busy & !exec_done);
      if (msg.msg_valid) begin
        wc <= wc + 4'd1;
        unique case (state)
          S_HDR: begin
            if_num     <= msg.msg_data[5:0];
            task_fence <= msg.msg_data[7:6];
            state      <= S_MASK;
          end
          S_MASK: begin
            sel_q <= hit & !busy;
            if (hit && busy)
              proto_err <= 1'b1;
            state <= S_R0M;
          end
          S_R0M: begin
            r0_sel_q <= sel_q & hit;
            state    <= S_R0D;
          end
          S_R0D: begin
            staging <= staging_nx;
            if (wc == R0_LAST) begin
              if (r0_sel_q) begin
                r0_value <= staging_nx;
                r0_load  <= 1'b1;
              end
              state <= S_PAD;
            end
          end
          S_PAD: begin
            if (frame_end) begin
              frame_idx <= 6'd0;
              state     <= task_end ? S_HDR : S_INSTR;
            end
          end
          S_INSTR: begin
            imem_we    <= sel_q;
            imem_addr  <= IMEM_AW'(addr_full);
            imem_wdata <= msg.msg_data;
            if (frame_end) begin
              if (task_end)
                state <= S_HDR;
              else
                frame_idx <= frame_idx + 6'd1;
            end
          end
          default: state <= S_HDR;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_core_msg_rx.sv
// Bench for core_msg_rx: vector table of whole tasks plus
// collision and mid-task reset sequences.
module tb_core_msg_rx;

  logic         clk = 1'b0;
  logic         reset;
  logic         exec_done;
  logic         core_ready;
  logic         imem_we;
  logic [9:0]   imem_addr;
  logic [15:0]  imem_wdata;
  logic [127:0] r0_value;
  logic         r0_load;
  logic         task_start;
  logic [1:0]   task_fence;
  logic         proto_err;

  core_msg_rx_if #(.BUS_WIDTH(16)) bus ();

  core_msg_rx #(
    .CORE_ID(3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .msg       (bus.slave),
    .exec_done (exec_done),
    .core_ready(core_ready),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .r0_value  (r0_value),
    .r0_load   (r0_load),
    .task_start(task_start),
    .task_fence(task_fence),
    .proto_err (proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] d;
  } wr_t;

  typedef struct {
    logic [15:0] hdr;
    logic [15:0] cm;
    logic [15:0] r0m;
    logic [15:0] r0b;
    logic [15:0] ib;
    bit          gap;
    bit          sel;
    bit          r0;
  } vec_t;

  wr_t          q[$];
  wr_t          e;
  int           tests = 0;
  int           fails = 0;
  int           r0_cnt = 0;
  int           ts_cnt = 0;
  logic [127:0] r0_exp = '0;
  bit           busy_m = 1'b0;
  vec_t         vecs[5];

  task automatic chk(input string n, input logic [127:0] act,
                     input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", n, act, exp);
    end
  endtask

  // Scoreboard: every write seen must match the oldest pushed one.
  always @(negedge clk) begin
    if (imem_we) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL imem_unexpected actual=%0h:%0h required=none",
                 imem_addr, imem_wdata);
      end else begin
        e = q.pop_front();
        if (imem_addr !== e.a[9:0] || imem_wdata !== e.d) begin
          fails++;
          $display("FAIL imem_write actual=%0h:%0h required=%0h:%0h",
                   imem_addr, imem_wdata, e.a[9:0], e.d);
        end
      end
    end
    if (r0_load) r0_cnt++;
    if (task_start) ts_cnt++;
  end

  task automatic put(input logic [15:0] w, input bit gap);
    if (gap) begin
      bus.msg_valid = 1'b0;
      @(posedge clk); #1;
    end
    bus.msg_valid = 1'b1;
    bus.msg_data  = w;
    @(posedge clk); #1;
    bus.msg_valid = 1'b0;
  endtask

  task automatic stream(input logic [15:0] hdr, input logic [15:0] cm,
                        input logic [15:0] r0m, input logic [15:0] r0b,
                        input logic [15:0] ib, input bit gap,
                        input bit sel, input int n_instr);
    put(hdr, gap);
    put(cm, gap);
    put(r0m, gap);
    for (int k = 0; k < 8; k++) put(r0b + 16'(k), gap);
    for (int k = 0; k < 5; k++) put(16'hFFFF, gap);
    for (int k = 0; k < n_instr; k++) begin
      if (sel) q.push_back('{a: 16'(k), d: ib + 16'(k)});
      put(ib + 16'(k), gap);
    end
  endtask

  task automatic finish_exec();
    exec_done = 1'b1;
    @(posedge clk); #1;
    exec_done = 1'b0;
    busy_m = 1'b0;
    chk("ready_after_exec", core_ready, 1'b1);
  endtask

  task automatic run_vec(input vec_t v);
    int r0c;
    int tc;
    r0c = r0_cnt;
    tc  = ts_cnt;
    stream(v.hdr, v.cm, v.r0m, v.r0b, v.ib, v.gap, v.sel,
           16 * int'(v.hdr[5:0]));
    chk("task_start", task_start, v.sel);
    chk("core_ready", core_ready, !(v.sel | busy_m));
    chk("task_fence", task_fence, v.hdr[7:6]);
    if (v.r0)
      for (int k = 0; k < 8; k++) r0_exp[16*k +: 16] = v.r0b + 16'(k);
    @(posedge clk); #1;
    chk("r0_value", r0_value, r0_exp);
    chk("r0_load_cnt", 128'(r0_cnt - r0c), 128'(v.r0));
    chk("task_start_cnt", 128'(ts_cnt - tc), 128'(v.sel));
    chk("imem_pending", 128'(q.size()), 0);
    if (v.sel) begin
      busy_m = 1'b1;
      finish_exec();
    end
  endtask

  initial begin
    vecs[0] = '{16'h0002, 16'h0008, 16'h0008, 16'h1000, 16'hA000, 0, 1, 1};
    vecs[1] = '{16'h0002, 16'h0004, 16'h0008, 16'h1100, 16'hA100, 0, 0, 0};
    vecs[2] = '{16'h0002, 16'h0008, 16'h0000, 16'h2000, 16'hB000, 0, 1, 0};
    vecs[3] = '{16'h0082, 16'h0008, 16'h0008, 16'h3000, 16'hC000, 1, 1, 1};
    vecs[4] = '{16'h00C0, 16'h0008, 16'h0008, 16'h4000, 16'h0000, 0, 1, 1};

    reset = 1'b1;
    exec_done = 1'b0;
    bus.msg_valid = 1'b0;
    bus.msg_data = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_core_ready", core_ready, 1'b1);
    chk("rst_imem_we", imem_we, 1'b0);
    chk("rst_r0_value", r0_value, '0);
    chk("rst_task_start", task_start, 1'b0);
    chk("rst_task_fence", task_fence, 2'd0);
    chk("rst_proto_err", proto_err, 1'b0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Task B arrives while task A is still executing.
    stream(16'h0001, 16'h0008, 16'h0000, 16'h6000, 16'hD000, 0, 1, 16);
    chk("coll_a_start", task_start, 1'b1);
    busy_m = 1'b1;
    stream(16'h0001, 16'h0008, 16'h0008, 16'h7000, 16'hE000, 0, 0, 16);
    chk("coll_b_start", task_start, 1'b0);
    chk("coll_proto_err", proto_err, 1'b1);
    chk("coll_ready", core_ready, 1'b0);
    @(posedge clk); #1;
    chk("coll_r0_value", r0_value, r0_exp);
    chk("coll_pending", 128'(q.size()), 0);
    finish_exec();
    chk("coll_err_sticky", proto_err, 1'b1);

    // Reset while instruction word 5 would be next.
    stream(16'h0042, 16'h0008, 16'h0008, 16'h5000, 16'hF000, 0, 1, 5);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    busy_m = 1'b0;
    r0_exp = '0;
    chk("mid_rst_ready", core_ready, 1'b1);
    chk("mid_rst_we", imem_we, 1'b0);
    chk("mid_rst_r0", r0_value, '0);
    chk("mid_rst_fence", task_fence, 2'd0);
    chk("mid_rst_err", proto_err, 1'b0);
    chk("mid_rst_pending", 128'(q.size()), 0);
    run_vec(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
